// File: rtl/msx_mouse_port.sv
// -----------------------------------------------------------------------------
// msx_mouse_port
//
// Turns PS/2 mouse packets into the MSX general-purpose-port mouse protocol.
// It sits between the ps2mouse decoder and the joystick port A input of
// emsx_top. Motion is accumulated between MSX reads. Each STROBE (pin 8) edge
// returns one nibble, in the order X-high, X-low, Y-high, Y-low. The physical
// joystick is passed through whenever the mouse is not in use.
//
// Parameters
//   TIMEOUT       clk_sys cycles without a STROBE edge before the nibble
//                 index falls back to 0
//
// Ports
//   clk_sys       system clock (emsx clk21m domain)
//   reset         synchronous, active-high
//   mouse_strobe  1-cycle pulse: new packet on mouse_dx / mouse_dy / mouse_btn
//   mouse_dx      signed X delta, two's complement, +right
//   mouse_dy      signed Y delta, two's complement, +up
//   mouse_btn     [0] left, [1] right, 1 = pressed
//   joy_in        physical joystick, active-low: [3:0] dirs, [5:4] triggers
//   msx_str       port STROBE from emsx, already in the clk_sys domain
//   port_out      active-low pin levels towards pJoyA
//   mouse_active  1 = the mouse drives port_out
// -----------------------------------------------------------------------------
module msx_mouse_port #(
   parameter int TIMEOUT = 100000
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       mouse_strobe,
   input  logic [8:0] mouse_dx,
   input  logic [8:0] mouse_dy,
   input  logic [1:0] mouse_btn,
   input  logic [5:0] joy_in,
   input  logic       msx_str,
   output logic [5:0] port_out,
   output logic       mouse_active
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic          str_d;
   logic [7:0]    acc_x;
   logic [7:0]    acc_y;
   logic [7:0]    lat_x;
   logic [7:0]    lat_y;
   logic [1:0]    nib_idx;
   logic [TW-1:0] tmo;

   logic          str_edge;
   logic          rd_edge;
   logic          rd_first;
   logic [7:0]    base_x;
   logic [7:0]    base_y;
   logic signed [9:0] sum_x;
   logic signed [9:0] sum_y;
   logic [3:0]    nibble;

   // Clamp a 10-bit signed sum to the 8-bit signed range.
   function automatic logic [7:0] sat8(input logic signed [9:0] v);
      if (v > 10'sd127)
         return 8'h7F;
      else if (v < -10'sd128)
         return 8'h80;
      else
         return v[7:0];
   endfunction

   // Either STROBE level change is a read; edges only count while the mouse
   // owns the port.
   assign str_edge = msx_str ^ str_d;
   assign rd_edge  = str_edge & mouse_active;
   assign rd_first = rd_edge && (nib_idx == 2'd0);

   // A read of nibble 0 snapshots and clears the accumulators in the same
   // cycle. A packet arriving then lands on the cleared value.
   assign base_x = rd_first ? 8'h00 : acc_x;
   assign base_y = rd_first ? 8'h00 : acc_y;

   // MSX counts +left, so X is subtracted. 10 bits holds any 8-bit + 9-bit sum.
   assign sum_x = $signed({{2{base_x[7]}}, base_x}) - $signed({mouse_dx[8], mouse_dx});
   assign sum_y = $signed({{2{base_y[7]}}, base_y}) + $signed({mouse_dy[8], mouse_dy});

   // NOTE: nibble gets a default before the case so no path can leave it unassigned and infer a latch.
   always_comb begin
      nibble = 4'h0;
      case (nib_idx)
         2'd0: nibble = acc_x[7:4];   // live accumulator, latched on this read
         2'd1: nibble = lat_x[3:0];
         2'd2: nibble = lat_y[7:4];
         2'd3: nibble = lat_y[3:0];
         default: nibble = 4'h0;
      endcase
   end

   // NOTE: every state update is non-blocking, so each branch below reads the pre-edge values.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         port_out     <= 6'h3F;
         mouse_active <= 1'b0;
         acc_x        <= 8'h00;
         acc_y        <= 8'h00;
         lat_x        <= 8'h00;
         lat_y        <= 8'h00;
         nib_idx      <= 2'd0;
         tmo          <= '0;
         // Sampling the current level here prevents a false edge right after reset.
         str_d        <= msx_str;
      end else begin
         str_d <= msx_str;

         // Accumulators run in both modes.
         if (mouse_strobe) begin
            acc_x <= sat8(sum_x);
            acc_y <= sat8(sum_y);
         end else if (rd_first) begin
            acc_x <= 8'h00;
            acc_y <= 8'h00;
         end

         if (rd_first) begin
            lat_x <= acc_x;
            lat_y <= acc_y;
         end

         // Nibble sequencing. An accepted edge on the last timeout cycle
         // takes precedence over the fallback to index 0.
         if (rd_edge) begin
            nib_idx <= nib_idx + 2'd1;
            tmo     <= TW'(TIMEOUT);
         end else begin
            if (tmo != '0)
               tmo <= tmo - TW'(1);
            if (tmo == TW'(1))
               nib_idx <= 2'd0;
         end

         // A mouse packet claims the port. Otherwise any joystick activity
         // releases it.
         if (mouse_strobe)
            mouse_active <= 1'b1;
         else if (joy_in != 6'h3F)
            mouse_active <= 1'b0;

         if (mouse_active) begin
            port_out[5:4] <= ~mouse_btn;
            if (rd_edge)
               port_out[3:0] <= nibble;
         end else begin
            port_out <= joy_in;
         end
      end
   end

endmodule

// File: tb/tb_msx_mouse_port.sv
module tb_msx_mouse_port;

   localparam int TMO = 64;

   logic       clk_sys = 1'b0;
   logic       reset = 1'b1;
   logic       mouse_strobe = 1'b0;
   logic [8:0] mouse_dx = '0;
   logic [8:0] mouse_dy = '0;
   logic [1:0] mouse_btn = '0;
   logic [5:0] joy_in = 6'h3F;
   logic       msx_str = 1'b0;
   logic [5:0] port_out;
   logic       mouse_active;

   always #5 clk_sys = ~clk_sys;

   msx_mouse_port #(.TIMEOUT(TMO)) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .mouse_strobe(mouse_strobe),
      .mouse_dx    (mouse_dx),
      .mouse_dy    (mouse_dy),
      .mouse_btn   (mouse_btn),
      .joy_in      (joy_in),
      .msx_str     (msx_str),
      .port_out    (port_out),
      .mouse_active(mouse_active)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: integer accumulators, a read counter, and the cycle
   // distance between accepted reads for the timeout rule.
   // ---------------------------------------------------------------------------
   int         m_ax, m_ay;
   logic [7:0] m_lx, m_ly;
   int         m_idx;
   logic       m_prev_str;
   logic [5:0] m_port;
   logic       m_active;
   longint     m_cyc, m_last_edge;
   bit         m_have_edge;
   bit         model_valid = 1'b0;

   function automatic int clamp8(input int v);
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   always @(posedge clk_sys) begin : model
      logic       take;
      logic [7:0] bx;
      logic [3:0] nib;
      int         dxv, dyv;
      model_valid = 1'b1;
      if (reset) begin
         m_ax = 0; m_ay = 0; m_lx = 8'h00; m_ly = 8'h00; m_idx = 0;
         m_prev_str = msx_str; m_port = 6'h3F; m_active = 1'b0;
         m_cyc = 0; m_last_edge = 0; m_have_edge = 1'b0;
      end else begin
         m_cyc++;
         take = (msx_str !== m_prev_str) && m_active;
         m_prev_str = msx_str;
         // More than TMO cycles since the previous read restarts the sequence.
         if (take && m_have_edge && (m_cyc - m_last_edge > TMO))
            m_idx = 0;
         bx = m_ax[7:0];
         case (m_idx)
            0:       nib = bx[7:4];
            1:       nib = m_lx[3:0];
            2:       nib = m_ly[7:4];
            default: nib = m_ly[3:0];
         endcase
         if (take && m_idx == 0) begin
            m_lx = m_ax[7:0]; m_ly = m_ay[7:0]; m_ax = 0; m_ay = 0;
         end
         if (mouse_strobe) begin
            dxv = $signed(mouse_dx);
            dyv = $signed(mouse_dy);
            m_ax = clamp8(m_ax - dxv);
            m_ay = clamp8(m_ay + dyv);
         end
         if (m_active) begin
            m_port[5:4] = ~mouse_btn;
            if (take) m_port[3:0] = nib;
         end else begin
            m_port = joy_in;
         end
         if (take) begin
            m_idx = (m_idx + 1) % 4; m_last_edge = m_cyc; m_have_edge = 1'b1;
         end
         if (mouse_strobe) m_active = 1'b1;
         else if (joy_in != 6'h3F) m_active = 1'b0;
      end
   end

   // Compare on every falling edge once the model has seen a clock.
   always @(negedge clk_sys) begin
      if (model_valid) begin
         check("model port_out", port_out, m_port);
         check("model mouse_active", mouse_active, m_active);
      end
   end

   // ---------------------------------------------------------------------------
   // Directed stimulus with literal expectations
   // ---------------------------------------------------------------------------
   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
   endtask

   task automatic send(input int dx, input int dy, input logic [1:0] btn);
      mouse_dx = 9'(dx); mouse_dy = 9'(dy); mouse_btn = btn; mouse_strobe = 1'b1;
      @(negedge clk_sys);
      mouse_strobe = 1'b0;
   endtask

   task automatic toggle_exp(input string name, input logic [3:0] exp);
      msx_str = ~msx_str;
      @(negedge clk_sys);
      check(name, port_out[3:0], exp);
   endtask

   // A read follows two reads after a gap of 'gap' cycles. The expected nibble
   // is the fresh X-high (E) after a timeout, or Y-high (5) otherwise.
   task automatic timeout_case(input int gap, input logic [3:0] exp);
      do_reset();
      send(5, 80, 2'b00);
      toggle_exp("tmo X-high", 4'hF);
      toggle_exp("tmo X-low", 4'hB);
      send(32, 0, 2'b00);
      repeat (gap - 2) @(negedge clk_sys);
      toggle_exp($sformatf("tmo gap %0d", gap), exp);
   endtask

   initial begin
      repeat (2) @(negedge clk_sys);
      check("reset port_out", port_out, 6'h3F);
      check("reset mouse_active", mouse_active, 1'b0);
      reset = 1'b0;
      joy_in = 6'h3E;
      @(negedge clk_sys);
      check("joy passthrough", port_out, 6'h3E);
      joy_in = 6'h3F;
      @(negedge clk_sys);

      // dx=+5, dy=+3 -> acc_x=FB, acc_y=03
      send(5, 3, 2'b01);
      check("strobe sets active", mouse_active, 1'b1);
      toggle_exp("basic n0", 4'hF);
      toggle_exp("basic n1", 4'hB);
      toggle_exp("basic n2", 4'h0);
      toggle_exp("basic n3", 4'h3);
      check("buttons", port_out[5:4], 2'b10);

      // Saturation at -128 on both axes
      do_reset();
      send(100, -256, 2'b00);
      send(100, -256, 2'b00);
      toggle_exp("sat X-high", 4'h8);
      toggle_exp("sat X-low", 4'h0);
      toggle_exp("sat Y-high", 4'h8);
      toggle_exp("sat Y-low", 4'h0);

      // Timeout boundary
      timeout_case(TMO - 1, 4'h5);
      timeout_case(TMO, 4'h5);
      timeout_case(TMO + 1, 4'hE);

      // Joystick takes the port back
      do_reset();
      send(1, 1, 2'b11);
      check("active before joy", mouse_active, 1'b1);
      joy_in = 6'h3B;
      @(negedge clk_sys);
      check("joy clears active", mouse_active, 1'b0);
      @(negedge clk_sys);
      check("joy port_out", port_out, 6'h3B);
      joy_in = 6'h3F;
      send(0, 0, 2'b00);
      check("strobe re-activates", mouse_active, 1'b1);

      // Packet in the same cycle as the index-0 read
      do_reset();
      send(5, 3, 2'b00);
      msx_str = ~msx_str;
      mouse_dx = 9'd2; mouse_dy = 9'd1; mouse_strobe = 1'b1;
      @(negedge clk_sys);
      mouse_strobe = 1'b0;
      check("coinc n0", port_out[3:0], 4'hF);
      toggle_exp("coinc n1", 4'hB);
      toggle_exp("coinc n2", 4'h0);
      toggle_exp("coinc n3", 4'h3);
      toggle_exp("coinc new n0", 4'hF);
      toggle_exp("coinc new n1", 4'hE);
      toggle_exp("coinc new n2", 4'h0);
      toggle_exp("coinc new n3", 4'h1);

      // Randomized traffic, with idle stretches around the timeout length
      for (int s = 0; s < 40; s++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(TMO - 4, TMO + 4)) @(negedge clk_sys);
         end else begin
            for (int c = 0; c < 100; c++) begin
               reset        = ($urandom_range(0, 299) == 0);
               mouse_strobe = ($urandom_range(0, 7) == 0);
               mouse_dx     = 9'($urandom);
               mouse_dy     = 9'($urandom);
               mouse_btn    = 2'($urandom);
               if ($urandom_range(0, 4) == 0) msx_str = ~msx_str;
               joy_in = ($urandom_range(0, 39) == 0) ? 6'($urandom) : 6'h3F;
               @(negedge clk_sys);
            end
            reset = 1'b0;
            mouse_strobe = 1'b0;
            joy_in = 6'h3F;
         end
      end

      @(negedge clk_sys);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
